// File: rtl/fp_align_shifter.sv
// fp_align_shifter: aligns the smaller-exponent mantissa of an FP operand pair for a downstream add/sub.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready accept a, b, op_sub;
// out_valid/out_ready hand off exp_out, mant_big, mant_small {mant,G,R,S},
// sign_big, sign_small, eff_sub, swapped.
module fp_align_shifter #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW+MW:0]  a,
  input  logic [EW+MW:0]  b,
  input  logic            op_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW-1:0]   exp_out,
  output logic [MW:0]     mant_big,
  output logic [MW+3:0]   mant_small,
  output logic            sign_big,
  output logic            sign_small,
  output logic            eff_sub,
  output logic            swapped
);
  localparam int CW = $clog2(MW + 5);
  localparam int XW = EW > CW ? EW : CW;
  typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [EW+MW:0] ra, rb;
  logic rop, borrow, sa, sb;
  logic [CW-1:0] cnt, cnt_c;
  logic [EW-1:0] ea, eb, eff_a, eff_b, diff, d;
  logic [MW:0] ma, mb;
  logic [XW-1:0] dx;
  assign ea = ra[EW+MW-1:MW];
  assign eb = rb[EW+MW-1:MW];
  // denormals carry hidden bit 0 and behave as exponent 1
  assign eff_a = ea == '0 ? EW'(1) : ea;
  assign eff_b = eb == '0 ? EW'(1) : eb;
  assign ma = {|ea, ra[MW-1:0]};
  assign mb = {|eb, rb[MW-1:0]};
  assign sa = ra[EW+MW];
  assign sb = rb[EW+MW] ^ rop;
  // borrow out of effA-effB means B is larger; ties keep A as the big operand
  assign {borrow, diff} = {1'b0, eff_a} - {1'b0, eff_b};
  assign d = borrow ? -diff : diff;
  assign dx = XW'(d);
  // shifting past the full aligned width only folds everything into sticky
  assign cnt_c = dx > XW'(MW + 4) ? CW'(MW + 4) : CW'(dx);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? (in_valid ? CALC : IDLE)
              : state == CALC  ? (cnt_c == '0 ? DONE : SHIFT)
              : state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT)
              : (out_ready ? IDLE : DONE);
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      ra         <= '0;
      rb         <= '0;
      rop        <= 1'b0;
      cnt        <= '0;
      exp_out    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      eff_sub    <= 1'b0;
      swapped    <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra  <= a;
      rb  <= b;
      rop <= op_sub;
    end else if (state == CALC) begin
      exp_out    <= borrow ? eff_b : eff_a;
      mant_big   <= borrow ? mb : ma;
      mant_small <= {borrow ? ma : mb, 3'b000};
      sign_big   <= borrow ? sb : sa;
      sign_small <= borrow ? sa : sb;
      eff_sub    <= sa ^ sb;
      swapped    <= borrow;
      cnt        <= cnt_c;
    end else if (state == SHIFT) begin
      // bit 0 is sticky: everything that passes through it stays ORed in
      mant_small <= {1'b0, mant_small[MW+3:2], mant_small[1] | mant_small[0]};
      cnt        <= cnt - CW'(1);
    end
endmodule

// File: doc/fp_align_shifter.md
FP_ALIGN_SHIFTER -- requirements
Module: fp_align_shifter

Interface
REQ-001 SHALL have parameter EW, default 8: exponent width.
REQ-002 SHALL have parameter MW, default 23: stored fraction width; the internal mantissa is MW+1 bits, the aligned mantissa MW+4 bits.
REQ-003 SHALL use a single clock and a synchronous active-low reset; all other signals are listed in REQ-004 to REQ-018.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  1+EW+MW  operand A, IEEE-754 layout {sign, exp, frac}.
REQ-009 b  input  1+EW+MW  operand B, same layout.
REQ-010 op_sub  input  1  1 = A-B, 0 = A+B; sampled with the operands.
REQ-011 out_valid  output  1  aligned result valid.
REQ-012 out_ready  input  1  downstream mantissa adder/subtractor accepts.
REQ-013 exp_out  output  EW  common (larger) exponent.
REQ-014 mant_big  output  MW+1  larger-exponent mantissa with hidden bit.
REQ-015 mant_small  output  MW+4  aligned mantissa {mant[MW:0], G, R, S}.
REQ-016 sign_big, sign_small  output  1 each  signs; sign_small already includes op_sub inversion when it comes from B.
REQ-017 eff_sub  output  1  sign_big XOR sign_small.
REQ-018 swapped  output  1  1 when B had the larger exponent.

Function
REQ-019 SHALL implement FSM states IDLE, CALC, SHIFT, DONE.
REQ-020 SHALL assert in_ready only in IDLE; in_valid&&in_ready SHALL register a, b and op_sub and move the FSM to CALC.
REQ-021 SHALL, on exp==0, use hidden bit 0 and effective exponent 1; on exp!=0, use hidden bit 1.
REQ-022 SHALL pass exp==all-ones through as an ordinary exponent, with no special-case handling.
REQ-023 CALC SHALL compute the EW-bit difference d = |effA-effB| using a subtract with borrow; the borrow out SHALL select the swap.
REQ-024 SHALL set swapped=1 only if effB>effA; on a tie, A SHALL be the big operand.
REQ-025 sign_small SHALL be b.sign^op_sub when B is the small operand, and a.sign when swapped.
REQ-026 CALC SHALL load the small mantissa as {mant,3'b000} and shift count cnt = min(d, MW+4).
REQ-027 CALC SHALL go to DONE if cnt==0, and to SHIFT otherwise.
REQ-028 Each SHIFT cycle SHALL perform m <= {0, m[MW+3:2], m[1]|m[0]} (sticky accumulate) and cnt <= cnt-1; the FSM SHALL go to DONE when cnt reaches 1 on the shift in progress.
REQ-029 Latency: out_valid SHALL rise 2+cnt cycles after the accept edge (e.g. d=1 -> 3 cycles).
REQ-030 out_valid SHALL be high only in DONE.
REQ-031 All outputs SHALL remain stable while out_valid && !out_ready.
REQ-032 out_valid&&out_ready SHALL return the FSM to IDLE, so in_ready=1 on the next cycle; no input is accepted in the same cycle as output consumption.
REQ-033 in_valid SHALL be ignored outside IDLE, and operands SHALL NOT change mid-operation.
REQ-034 exp_out SHALL equal the big operand's effective exponent (1 for a denormal).

Reset
REQ-035 rst_n low at a clock edge SHALL force IDLE, in_ready=1 (once reset is released), and out_valid=0.
REQ-036 rst_n low at a clock edge SHALL clear exp_out, mant_big, mant_small, sign_big, sign_small, eff_sub, swapped and cnt to 0.
REQ-037 Reset in any state, including mid-SHIFT, SHALL abort the operation with no output.
REQ-038 The first accept after reset SHALL behave as from power-up.

Verification
REQ-039 a=0x40000000, b=0x3F800000, op_sub=0 -> out_valid 3 cycles after accept; exp_out=0x80, mant_big=0x800000, mant_small=0x2000000, swapped=0, eff_sub=0.
REQ-040 a=0x3F800000, b=0x40000000, op_sub=1 -> swapped=1, sign_small=0, sign_big=1, eff_sub=1, mant_small=0x2000000.
REQ-041 a=0x4B800000, b=0x3F800001 -> d=24, out_valid 26 cycles after accept; mant_small=0x0000005 (sticky set).
REQ-042 a=0x7F000000, b=0x3F800000 -> d=127, cnt saturates at 27, latency 29; mant_small=0x0000001.
REQ-043 a=0x00000001, b=0x00800000 (denormal vs. min normal) -> d=0, latency 2; exp_out=1, mant_big=0x000001, mant_small=0x4000000.
REQ-044 Case REQ-039 with out_ready low for 5 cycles -> outputs constant, in_ready=0; after the handshake, in_ready=1 the next cycle.
REQ-045 Case REQ-041 with rst_n low for 1 cycle at shift 10 -> next cycle IDLE, all outputs 0, no out_valid pulse; a following REQ-039 transaction completes correctly.
